reset_stage_sequencer: RTL

- Controller that sequences the synchronous set_reset inputs of a bank of flop stages.
- Holds all stages in reset, then releases them one at a time in order, stage 0 first, with a fixed gap between releases.
- Runs automatically after system reset, and again on a request handshake from the control logic.
- Sits between the top-level reset and the per-stage set_reset pins of the sequential datapath.

---
 rtl/reset_stage_seq_pkg.sv | 24 ++
 rtl/seq_cycle_counter.sv | 29 ++
 rtl/reset_stage_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/reset_stage_seq_pkg.sv
// Shared types and sizing helpers for the reset stage sequencer.
package reset_stage_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HOLD       = 2'd1,
    ST_RELEASE    = 2'd2,
    ST_ASSERT_REV = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough to hold the larger of the two interval lengths.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    return $clog2(max_int(hold_cycles, gap_cycles) + 1);
  endfunction

  function automatic int idx_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// Loadable down-counter that saturates at zero; tc_o flags the terminal count.
module seq_cycle_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/reset_stage_sequencer.sv
// Holds a bank of stages in reset, then releases them in order with a fixed gap.
// Optional macro SEQ_REVERSE_ASSERT_EN: requested sequences assert stages one by one, highest first.
module reset_stage_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  seq_req,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [NUM_STAGES-1:0] stage_set_reset
);
  import reset_stage_seq_pkg::*;

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = idx_width(NUM_STAGES);

  // Reset loads the full hold length: the first edge with reset_n high is
  // cycle 0 and still counts, whereas an accept edge is itself cycle 0.
  localparam logic [CW-1:0] HOLD_RST = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fsm_load;
  logic [CW-1:0]         fsm_load_val;
  logic                  cnt_load;
  logic [CW-1:0]         cnt_load_val;
  logic                  cnt_en;
  logic                  cnt_tc;

  assign cnt_load     = !reset_n || fsm_load;
  assign cnt_load_val = reset_n ? fsm_load_val : HOLD_RST;
  assign cnt_en       = (state_q != ST_IDLE);

  seq_cycle_counter #(
    .WIDTH(CW)
  ) u_counter (
    .clk       (clk),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .en_i      (cnt_en),
    .tc_o      (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    stage_d      = stage_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fsm_load     = 1'b0;
    fsm_load_val = HOLD_LD;

    case (state_q)
      ST_HOLD: begin
        if (cnt_tc) begin
          stage_d[0]   = 1'b0;
          idx_d        = '0;
          state_d      = ST_RELEASE;
          fsm_load     = 1'b1;
          fsm_load_val = GAP_LD;
        end
      end

      ST_RELEASE: begin
        // idx_q is the most recently released stage.
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_tc) begin
          idx_d                      = idx_q + IW'(1);
          stage_d[idx_q + IW'(1)]    = 1'b0;
          fsm_load                   = 1'b1;
          fsm_load_val               = GAP_LD;
        end
      end

      ST_ASSERT_REV: begin
        if (cnt_tc) begin
          idx_d                   = idx_q - IW'(1);
          stage_d[idx_q - IW'(1)] = 1'b1;
          fsm_load                = 1'b1;
          if (idx_q == IW'(1)) begin
            state_d      = ST_HOLD;
            fsm_load_val = HOLD_LD;
          end else begin
            fsm_load_val = GAP_LD;
          end
        end
      end

      ST_IDLE: begin
        if (seq_req) begin
          busy_d   = 1'b1;
          fsm_load = 1'b1;
`ifdef SEQ_REVERSE_ASSERT_EN
          if (NUM_STAGES > 1) begin
            stage_d[LAST_IDX] = 1'b1;
            idx_d             = LAST_IDX;
            fsm_load_val      = GAP_LD;
            state_d           = ST_ASSERT_REV;
          end else begin
            stage_d      = '1;
            fsm_load_val = HOLD_LD;
            state_d      = ST_HOLD;
          end
`else
          stage_d      = '1;
          fsm_load_val = HOLD_LD;
          state_d      = ST_HOLD;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_HOLD;
      idx_q   <= '0;
      stage_q <= '1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stage_set_reset = stage_q;
  assign seq_busy        = busy_q;
  assign seq_done        = done_q;

endmodule
